// File: rtl/pio_fifo.sv
// Show-ahead synchronous FIFO between the host and one PIO machine; join_en doubles capacity.
// Define PIO_FIFO_STICKY_EN to add sticky overflow/underflow flags with a clr_sticky input.
module pio_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        join_en,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pull,
    output logic [WIDTH-1:0]            dout,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(2*DEPTH):0]    level
`ifdef PIO_FIFO_STICKY_EN
    ,
    input  logic                        clr_sticky,
    output logic                        overflow,
    output logic                        underflow
`endif
);

    localparam int PW = $clog2(2*DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] LAST_J = PW'(2*DEPTH - 1);
    localparam logic [PW-1:0] LAST_N = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [2*DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             join_q;
    logic [LW-1:0]    cap;
    logic             clear;
    logic             push_acc;
    logic             pull_acc;

    // Pointers wrap at the current capacity, not at the physical array size.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic jn);
        return (p == (jn ? LAST_J : LAST_N)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cap      = join_q ? LW'(2*DEPTH) : LW'(DEPTH);
        empty    = (level_q == '0);
        full     = (level_q == cap);
        clear    = flush | (join_en != join_q);
        push_acc = push & (~full | pull) & ~clear;
        pull_acc = pull & ~empty & ~clear;
        level    = level_q;
        dout     = (level_q != '0) ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            join_q  <= 1'b0;
        end else begin
            join_q <= join_en;
            if (clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push_acc) wr_ptr <= ptr_inc(wr_ptr, join_q);
                if (pull_acc) rd_ptr <= ptr_inc(rd_ptr, join_q);
                unique case ({push_acc, pull_acc})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= din;
    end

`ifdef PIO_FIFO_STICKY_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push & ~push_acc) ovf_q <= 1'b1;
            else if (clr_sticky)  ovf_q <= 1'b0;
            if (pull & ~pull_acc) unf_q <= 1'b1;
            else if (clr_sticky)  unf_q <= 1'b0;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_pio_fifo.sv
// Directed table-driven bench for pio_fifo (WIDTH=32, DEPTH=4).
module tb_pio_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(2*DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             join_en = 1'b0;
    logic             flush = 1'b0;
    logic             push = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             pull = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [LW-1:0]    level;
`ifdef PIO_FIFO_STICKY_EN
    logic             clr_sticky = 1'b0;
    logic             overflow;
    logic             underflow;
`endif

    pio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .join_en(join_en),
        .flush(flush),
        .push(push),
        .din(din),
        .pull(pull),
        .dout(dout),
        .empty(empty),
        .full(full),
        .level(level)
`ifdef PIO_FIFO_STICKY_EN
        ,
        .clr_sticky(clr_sticky),
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pull;
        logic        flush;
        logic        jn;
        logic [31:0] din;
        int          lvl;
        logic        emp;
        logic        ful;
        logic [31:0] dout;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic pu, input logic pl, input logic fl, input logic jn,
                       input logic [31:0] d, input int lv, input logic em, input logic fu,
                       input logic [31:0] dq, input logic ov, input logic un);
        vec_t v;
        v.push = pu; v.pull = pl; v.flush = fl; v.jn = jn; v.din = d;
        v.lvl = lv; v.emp = em; v.ful = fu; v.dout = dq; v.ovf = ov; v.unf = un;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input int lv, input logic em,
                              input logic fu, input logic [31:0] dq);
        check({tag, "_level"}, idx, 32'(level), 32'(lv));
        check({tag, "_empty"}, idx, 32'(empty), 32'(em));
        check({tag, "_full"},  idx, 32'(full),  32'(fu));
        check({tag, "_dout"},  idx, dout, dq);
    endtask

    initial begin
        // push, pull, flush, join, din | level, empty, full, dout, ovf, unf
        add(1,0,0,0,32'h11, 1,0,0,32'h11, 0,0);
        add(1,0,0,0,32'h22, 2,0,0,32'h11, 0,0);
        add(1,0,0,0,32'h33, 3,0,0,32'h11, 0,0);
        add(1,0,0,0,32'h44, 4,0,1,32'h11, 0,0);
        add(1,0,0,0,32'h55, 4,0,1,32'h11, 1,0);
        add(1,1,0,0,32'h55, 4,0,1,32'h22, 1,0);
        add(0,1,0,0,32'h0,  3,0,0,32'h33, 1,0);
        add(0,1,0,0,32'h0,  2,0,0,32'h44, 1,0);
        add(0,1,0,0,32'h0,  1,0,0,32'h55, 1,0);
        add(0,1,0,0,32'h0,  0,1,0,32'h0,  1,0);
        add(0,1,0,0,32'h0,  0,1,0,32'h0,  1,1);
        add(1,0,0,0,32'hAA, 1,0,0,32'hAA, 1,1);
        add(1,0,0,0,32'hBB, 2,0,0,32'hAA, 1,1);
        add(0,0,0,1,32'h0,  0,1,0,32'h0,  0,0);
        for (int k = 0; k < 8; k++)
            add(1,0,0,1,32'(k), k+1,0,(k == 7),32'h0, 0,0);
        add(1,0,0,1,32'h8,  8,0,1,32'h0, 1,0);
        add(0,1,0,1,32'h0,  7,0,0,32'h1, 1,0);
        add(0,1,0,1,32'h0,  6,0,0,32'h2, 1,0);
        add(1,0,0,1,32'h8,  7,0,0,32'h2, 1,0);
        add(1,0,0,1,32'h9,  8,0,1,32'h2, 1,0);
        for (int k = 0; k < 8; k++)
            add(0,1,0,1,32'h0, 7-k,(k == 7),0,(k == 7) ? 32'h0 : 32'(k+3), 1,0);
        add(1,1,0,1,32'h77, 1,0,0,32'h77, 1,1);
        add(0,1,0,1,32'h0,  0,1,0,32'h0,  1,1);
        add(1,0,0,1,32'hC0, 1,0,0,32'hC0, 1,1);
        add(1,1,0,0,32'hC1, 0,1,0,32'h0,  0,0);
        add(1,0,0,0,32'h1,  1,0,0,32'h1,  0,0);
        add(1,0,0,0,32'h2,  2,0,0,32'h1,  0,0);
        add(1,0,1,0,32'h3,  0,1,0,32'h0,  0,0);
        add(1,0,0,0,32'h4,  1,0,0,32'h4,  0,0);

        // Reset state
        #12;
        check_outs("reset", -1, 0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            push = vq[i].push; pull = vq[i].pull; flush = vq[i].flush;
            join_en = vq[i].jn; din = vq[i].din;
            @(posedge clk);
            #1;
            check_outs("vec", i, vq[i].lvl, vq[i].emp, vq[i].ful, vq[i].dout);
`ifdef PIO_FIFO_STICKY_EN
            check("vec_overflow",  i, 32'(overflow),  32'(vq[i].ovf));
            check("vec_underflow", i, 32'(underflow), 32'(vq[i].unf));
`endif
        end

        // Asynchronous reset mid-burst, write pointer away from zero
        push = 1'b1; pull = 1'b0; flush = 1'b0; din = 32'h5;
        @(posedge clk); #1;
        din = 32'h6;
        @(posedge clk); #1;
        check("pre_reset_level", 0, 32'(level), 32'd3);
        din = 32'h7;
        #2 reset = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 1'b1, 1'b0, 32'h0);
        push = 1'b0;
        #2 reset = 1'b1;
        push = 1'b1; din = 32'hE0;
        @(posedge clk); #1;
        push = 1'b0;
        check_outs("post_rst", 0, 1, 1'b0, 1'b0, 32'hE0);
        check("post_rst_mem0", 0, dut.mem[0], 32'hE0);

`ifdef PIO_FIFO_STICKY_EN
        // Sticky clear: set wins over clr_sticky in the same cycle
        check("stk_ovf_after_rst", 0, 32'(overflow), 32'd0);
        pull = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stk_unf_set", 0, 32'(underflow), 32'd1);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        check("stk_set_wins", 0, 32'(underflow), 32'd1);
        pull = 1'b0;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        check("stk_cleared", 0, 32'(underflow), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
